pwm_multi_ch: RTL and testbench
===============================

// Module: pwm_multi_ch
// PURPOSE
//  Multi-channel PWM generator; single clock domain, no derived clocks.
//  A shared prescaler drives one shared period counter.
//  Edge-aligned or center-aligned period counter.
//  Per-channel duty is double-buffered (shadow -> active at period boundary); glitch-free updates.
//  Drives the PWM pins of the top-level wrapper; per_o syncs downstream logic.
// PARAMETERS
//  CH     4  number of PWM channels
//  W      8  counter / duty / top width (bits)
//  PRE_W  8  prescaler width (bits)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       asynchronous active-low reset
//  ena        in   1       block enable; low = counters cleared and held, outputs low
//  top_i      in   W       period top value; latched at period boundary
//  center_i   in   1       0 = edge-aligned, 1 = center-aligned; latched at boundary
//  prescale_i in   PRE_W   tick every prescale_i+1 clk cycles; sampled live
//  duty_i     in   CH*W    duty per channel; channel c = duty_i[c*W +: W]
//  duty_ld_i  in   1       load all duty_i into shadow registers
//  pwm_o      out  CH      PWM outputs, registered
//  per_o      out  1       one-clk pulse; counter restarted at 0
// BEHAVIOUR
//  Reset (async): pre_cnt=0, cnt=0, dir=up, shadow=0, active duty=0, top_act=0, center_act=0, pwm_o=0, per_o=0.
//  Prescaler:
//   - tick=1 when pre_cnt>=prescale_i; pre_cnt then returns to 0, else increments.
//   - prescale_i=0 gives a tick every cycle.
//   - A live prescale_i decrease below pre_cnt gives a tick next cycle, with no wrap-around.
//  ena=0: pre_cnt, cnt, dir forced to reset values; pwm_o=0, per_o=0. Shadow loads still accepted.
//  Counter (advances only on tick):
//   - Edge mode: 0,1..top_act,0,... Period = top_act+1 ticks.
//   - Center mode: up 0..top_act, then down top_act-1..1, then 0. Period = 2*top_act ticks.
//   - Either mode, top_act=0: cnt stays 0 and every tick is a boundary.
//  Boundary:
//   - The tick that makes the next cnt 0, or the first tick after reset or ena rise (cnt held 0).
//   - At a boundary: top_act<=top_i, center_act<=center_i, active[c]<=shadow[c].
//   - per_o=1 in the clk cycle after the boundary tick, else 0.
//  Shadow:
//   - duty_ld_i=1 samples duty_i into all shadows.
//   - If duty_ld_i coincides with a boundary tick, active takes duty_i directly (bypass).
//  Output:
//   - pwm_o[c] <= ena & (cnt < active[c]). Registered compare; lags cnt by 1 clk.
//   - duty=0: always low.
//   - Edge mode, duty>top_act: always high.
//   - Center mode, duty>top_act: always high.
//   - Center mode, 1<=duty<=top_act: high for 2*duty-1 ticks, symmetric about cnt=0.
//  Compare is unsigned, W bits. No overflow: cnt never exceeds top_act <= 2^W-1.
//  Reset mid-period: outputs drop low immediately (async); restart as after power-up.
// TESTING
//  - Edge, W=8, top=9, prescale=0, duty0=3, ld once -> pwm_o[0] high 3 of every 10 clks; per_o every 10 clks.
//  - Prescale=3, top=4, duty=2 -> period 20 clks, high 8 clks; per_o width exactly 1 clk.
//  - Center, top=4, duty=2 -> period 8 ticks, high 3 ticks (cnt 1,0,1); duty=5 -> constant high.
//  - Load duty 3->7 mid-period -> current period keeps 3; next period after per_o uses 7.
//  - duty_ld_i on the boundary tick -> the new duty applies in the period just starting.
//  - Assert rst_n=0 mid-high -> pwm_o=0 same cycle; ena=0 -> all low, per_o silent.
//  - duty=0 and duty=255, top=254 -> constant low and constant high; no glitches across boundaries.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: shared prescaler and period counter (edge or center aligned),
// per-channel double-buffered duty with registered compare outputs.
module pwm_multi_ch #(
    parameter int unsigned CH    = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned PRE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [W-1:0]      top_i,
    input  logic              center_i,
    input  logic [PRE_W-1:0]  prescale_i,
    input  logic [CH*W-1:0]   duty_i,
    input  logic              duty_ld_i,
    output logic [CH-1:0]     pwm_o,
    output logic              per_o
);

    localparam logic [0:0] DIR_UP = 1'b0;
    localparam logic [0:0] DIR_DN = 1'b1;

    logic [PRE_W-1:0]      pre_cnt, pre_nxt;
    logic [W-1:0]          cnt, cnt_nxt;
    logic [0:0]            dir, dir_nxt;
    logic                  run;
    logic [W-1:0]          top_act;
    logic                  center_act;
    logic [CH-1:0][W-1:0]  shadow;
    logic [CH-1:0][W-1:0]  active;
    logic                  tick_c;
    logic                  bnd_c;
    logic [CH-1:0]         pwm_nxt;

    // Prescaler, counter and direction next-state
    always_comb begin
        tick_c  = 1'b0;
        bnd_c   = 1'b0;
        pre_nxt = '0;
        cnt_nxt = '0;
        dir_nxt = DIR_UP;
        if (ena) begin
            tick_c  = (pre_cnt >= prescale_i);
            pre_nxt = tick_c ? '0 : pre_cnt + PRE_W'(1);
            cnt_nxt = cnt;
            dir_nxt = dir;
            if (tick_c) begin
                if (!run) begin
                    cnt_nxt = '0;
                end else if (!center_act) begin
                    cnt_nxt = (cnt >= top_act) ? '0 : cnt + W'(1);
                end else if (dir == DIR_UP) begin
                    if (cnt >= top_act) begin
                        cnt_nxt = (top_act == '0) ? '0 : cnt - W'(1);
                        dir_nxt = DIR_DN;
                    end else begin
                        cnt_nxt = cnt + W'(1);
                    end
                end else begin
                    cnt_nxt = cnt - W'(1);
                end
                // First tick after start-up is a boundary too, so a fresh period begins at 0
                bnd_c = !run || (cnt_nxt == '0);
                if (bnd_c) begin
                    dir_nxt = DIR_UP;
                end
            end
        end
    end

    always_comb begin
        pwm_nxt = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            pwm_nxt[c] = ena && (cnt < active[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            cnt     <= '0;
            dir     <= DIR_UP;
            run     <= 1'b0;
        end else begin
            pre_cnt <= pre_nxt;
            cnt     <= cnt_nxt;
            dir     <= dir_nxt;
            run     <= ena && (run || tick_c);
        end
    end

    // Period configuration and duty buffers; a load on the boundary tick bypasses the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_act    <= '0;
            center_act <= 1'b0;
            shadow     <= '0;
            active     <= '0;
        end else begin
            if (duty_ld_i) begin
                shadow <= duty_i;
            end
            if (bnd_c) begin
                top_act    <= top_i;
                center_act <= center_i;
                active     <= duty_ld_i ? duty_i : shadow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_o <= '0;
            per_o <= 1'b0;
        end else begin
            pwm_o <= pwm_nxt;
            per_o <= bnd_c;
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Testbench for pwm_multi_ch: directed period/duty scenarios plus randomized traffic
// checked against a phase-based reference model.
module tb_pwm_multi_ch;
    localparam int unsigned CH    = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned PRE_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic [W-1:0]      top;
    logic              center;
    logic [PRE_W-1:0]  prescale;
    logic [CH*W-1:0]   duty;
    logic              duty_ld;
    logic [CH-1:0]     pwm;
    logic              per;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pwm_multi_ch #(.CH(CH), .W(W), .PRE_W(PRE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .top_i      (top),
        .center_i   (center),
        .prescale_i (prescale),
        .duty_i     (duty),
        .duty_ld_i  (duty_ld),
        .pwm_o      (pwm),
        .per_o      (per)
    );

    // Reference model: position within the period as a phase index, counter value derived from it
    int            m_pre, m_ph, m_top, m_len, m_cnt;
    bit            m_run, m_ctr, m_tk, m_bd;
    int            m_sh [CH];
    int            m_act[CH];
    logic [CH-1:0] e_pwm;
    logic          e_per;

    task automatic model_step();
        if (!rst_n) begin
            m_pre = 0; m_ph = 0; m_run = 0; m_top = 0; m_ctr = 0;
            e_pwm = '0; e_per = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_sh[c] = 0; m_act[c] = 0;
            end
        end else begin
            m_cnt = (m_ctr && m_ph > m_top) ? 2 * m_top - m_ph : m_ph;
            for (int c = 0; c < CH; c++) e_pwm[c] = ena && (m_cnt < m_act[c]);
            m_len = m_ctr ? ((m_top == 0) ? 1 : 2 * m_top) : m_top + 1;
            m_tk  = ena && (m_pre >= int'(prescale));
            m_bd  = 1'b0;
            if (!ena) begin
                m_pre = 0; m_ph = 0; m_run = 0;
            end else begin
                m_pre = m_tk ? 0 : m_pre + 1;
                if (m_tk) begin
                    if (!m_run) m_bd = 1'b1;
                    else begin
                        m_ph++;
                        if (m_ph >= m_len) begin m_ph = 0; m_bd = 1'b1; end
                    end
                    m_run = 1'b1;
                end
            end
            e_per = m_bd;
            if (m_bd) begin
                m_top = int'(top);
                m_ctr = center;
                for (int c = 0; c < CH; c++) m_act[c] = duty_ld ? int'(duty[c*W +: W]) : m_sh[c];
            end
            if (duty_ld) for (int c = 0; c < CH; c++) m_sh[c] = int'(duty[c*W +: W]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    task automatic load_duty();
        duty_ld = 1'b1;
        @(negedge clk);
        duty_ld = 1'b0;
    endtask

    task automatic restart();
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clk);
        n_chk++;
        if (pwm !== '0 || per !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: pwm_o=%b per_o=%b, required 0000/0", pwm, per);
        end
        rst_n = 1'b1;
        ena   = 1'b1;
        bad   = 0;
        repeat (5) begin
            @(negedge clk);
            if (pwm !== e_pwm || per !== e_per) bad++;
        end
        n_chk++;
        if (pwm !== '0 || per !== 1'b1) begin
            n_err++;
            $display("FAIL reset_top0: pwm_o=%b per_o=%b, required 0000/1", pwm, per);
        end
        n_chk++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_model: %0d cycles differ, required 0", bad);
        end
    endtask

    task automatic test_edge_basic();
        int bad, hi, pc;
        top = 8'd9; center = 1'b0; prescale = '0; duty = '0; duty[0 +: W] = 8'd3;
        load_duty();
        restart();
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (pwm !== e_pwm || per !== e_per) bad++;
        end
        hi = 0; pc = 0;
        repeat (10) begin
            @(negedge clk);
            hi += int'(pwm[0]); pc += int'(per);
        end
        n_chk++;
        if (bad != 0) begin n_err++; $display("FAIL edge_model: %0d cycles differ, required 0", bad); end
        n_chk++;
        if (hi != 3) begin n_err++; $display("FAIL edge_high: pwm_o[0] high %0d of 10 clks, required 3", hi); end
        n_chk++;
        if (pc != 1) begin n_err++; $display("FAIL edge_per: per_o pulses %0d in 10 clks, required 1", pc); end
    endtask

    task automatic test_prescale();
        int bad, hi, pc, wide;
        logic prev;
        top = 8'd4; center = 1'b0; prescale = 8'd3; duty = '0; duty[0 +: W] = 8'd2;
        load_duty();
        restart();
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (pwm !== e_pwm || per !== e_per) bad++;
        end
        hi = 0; pc = 0; wide = 0; prev = per;
        repeat (20) begin
            @(negedge clk);
            hi += int'(pwm[0]); pc += int'(per);
            if (per && prev) wide++;
            prev = per;
        end
        n_chk++;
        if (bad != 0) begin n_err++; $display("FAIL pre_model: %0d cycles differ, required 0", bad); end
        n_chk++;
        if (hi != 8) begin n_err++; $display("FAIL pre_high: pwm_o[0] high %0d of 20 clks, required 8", hi); end
        n_chk++;
        if (pc != 1 || wide != 0) begin
            n_err++;
            $display("FAIL pre_per: per_o pulses %0d, wide %0d in 20 clks, required 1 and 0", pc, wide);
        end
    endtask

    task automatic test_prescale_decrease();
        int pc;
        top = '0; center = 1'b0; prescale = 8'd100;
        restart();
        repeat (30) @(negedge clk);
        prescale = 8'd5;
        @(negedge clk);
        n_chk++;
        if (per !== 1'b1) begin n_err++; $display("FAIL pre_dec_tick: per_o=%b, required 1", per); end
        pc = 0;
        repeat (5) begin @(negedge clk); pc += int'(per); end
        @(negedge clk);
        n_chk++;
        if (pc != 0 || per !== 1'b1) begin
            n_err++;
            $display("FAIL pre_dec_next: gap pulses %0d, sixth per_o=%b, required 0 and 1", pc, per);
        end
    endtask

    task automatic test_center();
        int bad, hi0, hi1, pc;
        top = 8'd4; center = 1'b1; prescale = '0; duty = '0;
        duty[0 +: W] = 8'd2; duty[W +: W] = 8'd5;
        load_duty();
        restart();
        bad = 0;
        repeat (24) begin
            @(negedge clk);
            if (pwm !== e_pwm || per !== e_per) bad++;
        end
        hi0 = 0; hi1 = 0; pc = 0;
        repeat (8) begin
            @(negedge clk);
            hi0 += int'(pwm[0]); hi1 += int'(pwm[1]); pc += int'(per);
        end
        n_chk++;
        if (bad != 0) begin n_err++; $display("FAIL ctr_model: %0d cycles differ, required 0", bad); end
        n_chk++;
        if (hi0 != 3 || pc != 1) begin
            n_err++;
            $display("FAIL ctr_duty2: high %0d per %0d in 8 clks, required 3 and 1", hi0, pc);
        end
        n_chk++;
        if (hi1 != 8) begin n_err++; $display("FAIL ctr_duty5: high %0d of 8 clks, required 8", hi1); end
    endtask

    task automatic test_mid_load();
        int hi1, hi2;
        bit got;
        top = 8'd9; center = 1'b0; prescale = '0; duty = '0; duty[0 +: W] = 8'd3;
        load_duty();
        restart();
        repeat (20) @(negedge clk);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (per === 1'b1) got = 1'b1;
        end
        n_chk++;
        if (!got) begin n_err++; $display("FAIL mid_wait: per_o=0 after 40 clks, required a pulse"); end
        hi1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            hi1 += int'(pwm[0]);
            duty_ld = (i == 3);
            if (i == 3) duty[0 +: W] = 8'd7;
        end
        duty_ld = 1'b0;
        hi2 = 0;
        repeat (10) begin @(negedge clk); hi2 += int'(pwm[0]); end
        n_chk++;
        if (hi1 != 3 || hi2 != 7) begin
            n_err++;
            $display("FAIL mid_load: highs %0d then %0d, required 3 then 7", hi1, hi2);
        end
    endtask

    task automatic test_boundary_load();
        int hi;
        bit got;
        top = 8'd9; center = 1'b0; prescale = '0; duty = '0; duty[0 +: W] = 8'd3;
        load_duty();
        restart();
        repeat (20) @(negedge clk);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (per === 1'b1) got = 1'b1;
        end
        repeat (9) @(negedge clk);
        duty[0 +: W] = 8'd6;
        duty_ld = 1'b1;
        @(negedge clk);
        duty_ld = 1'b0;
        n_chk++;
        if (!got || per !== 1'b1) begin
            n_err++;
            $display("FAIL bnd_per: pulse seen %0d, per_o=%b at boundary, required 1/1", got, per);
        end
        hi = 0;
        repeat (10) begin @(negedge clk); hi += int'(pwm[0]); end
        n_chk++;
        if (hi != 6) begin n_err++; $display("FAIL bnd_bypass: high %0d of 10 clks, required 6", hi); end
    endtask

    task automatic test_ena();
        int bad, busy, hi;
        top = 8'd9; center = 1'b0; prescale = '0;
        ena = 1'b0;
        @(negedge clk);
        duty = '0; duty[0 +: W] = 8'd5;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pwm !== '0 || per !== 1'b0) busy++;
            duty_ld = (i == 4);
        end
        duty_ld = 1'b0;
        n_chk++;
        if (busy != 0) begin n_err++; $display("FAIL ena_off: %0d active clks, required 0", busy); end
        ena = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (pwm !== e_pwm || per !== e_per) bad++;
        end
        hi = 0;
        repeat (10) begin @(negedge clk); hi += int'(pwm[0]); end
        n_chk++;
        if (bad != 0 || hi != 5) begin
            n_err++;
            $display("FAIL ena_shadow: model diffs %0d, high %0d of 10, required 0 and 5", bad, hi);
        end
    endtask

    task automatic test_extremes();
        int bad, lo_hi, hi_lo;
        top = 8'd254; center = 1'b0; prescale = '0;
        duty = {8'd254, 8'd128, 8'd255, 8'd0};
        load_duty();
        restart();
        repeat (10) @(negedge clk);
        bad = 0; lo_hi = 0; hi_lo = 0;
        repeat (600) begin
            @(negedge clk);
            if (pwm !== e_pwm || per !== e_per) bad++;
            if (pwm[0] !== 1'b0) lo_hi++;
            if (pwm[1] !== 1'b1) hi_lo++;
        end
        n_chk++;
        if (lo_hi != 0 || hi_lo != 0) begin
            n_err++;
            $display("FAIL extremes: duty0 high %0d clks, duty255 low %0d clks, required 0 and 0", lo_hi, hi_lo);
        end
        n_chk++;
        if (bad != 0) begin n_err++; $display("FAIL ext_model: %0d cycles differ, required 0", bad); end
    endtask

    task automatic test_reset_mid();
        int bad;
        bit got;
        top = 8'd9; center = 1'b0; prescale = '0; duty = '0; duty[0 +: W] = 8'd8;
        load_duty();
        restart();
        repeat (15) @(negedge clk);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (pwm[0] === 1'b1) got = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (!got || pwm !== '0 || per !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: high seen %0d, pwm_o=%b per_o=%b, required 1, 0000/0", got, pwm, per);
        end
        @(negedge clk);
        rst_n = 1'b1;
        load_duty();
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (pwm !== e_pwm || per !== e_per) bad++;
        end
        n_chk++;
        if (bad != 0) begin n_err++; $display("FAIL rst_restart: %0d cycles differ, required 0", bad); end
    endtask

    task automatic test_random();
        int bad, first;
        logic [CH-1:0] got_pwm, exp_pwm;
        logic got_per, exp_per;
        bad = 0; first = -1;
        got_pwm = '0; exp_pwm = '0; got_per = 1'b0; exp_per = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (pwm !== e_pwm || per !== e_per) begin
                if (bad == 0) begin
                    first = i; got_pwm = pwm; exp_pwm = e_pwm; got_per = per; exp_per = e_per;
                end
                bad++;
            end
            if ($urandom_range(0, 15) == 0) top = W'($urandom_range(0, 12));
            if ($urandom_range(0, 31) == 0) center = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) prescale = PRE_W'($urandom_range(0, 7));
            for (int c = 0; c < CH; c++) duty[c*W +: W] = W'($urandom_range(0, 15));
            duty_ld = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) ena = 1'b0;
            else if ($urandom_range(0, 3) == 0) ena = 1'b1;
        end
        duty_ld = 1'b0;
        ena = 1'b1;
        n_chk++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL random: %0d cycles differ (first at %0d pwm_o=%b per_o=%b), required pwm_o=%b per_o=%b",
                     bad, first, got_pwm, got_per, exp_pwm, exp_per);
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; top = '0; center = 1'b0;
        prescale = '0; duty = '0; duty_ld = 1'b0;
        test_reset();
        test_edge_basic();
        test_prescale();
        test_prescale_decrease();
        test_center();
        test_mid_load();
        test_boundary_load();
        test_ena();
        test_extremes();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
